// File: rtl/visualizador_producto.sv
`default_nettype none
// ============================================================================
// Module  : visualizador_producto
// Brief   : Signed product -> sign + BCD (sequential double-dabble), buffered
//           and scanned onto an 8-position multiplexed 7-segment display.
// Revision: 1.0  initial release
// ============================================================================
module visualizador_producto #(
    parameter int ANCHO_PRODUCTO = 16,
    parameter int N_DIGITOS      = 5
) (
    input  logic                      reloj,
    input  logic                      reset,
    input  logic                      producto_valido,
    input  logic [ANCHO_PRODUCTO-1:0] producto,
    input  logic [2:0]                contador_actualizar,
    output logic                      ocupado,
    output logic                      listo,
    output logic [7:0]                anodos,
    output logic [6:0]                segmentos
);

    localparam int c_ANCHO_BCD = 4 * N_DIGITOS;
    localparam int c_ANCHO_CNT = $clog2(ANCHO_PRODUCTO);
    localparam logic [c_ANCHO_CNT-1:0] c_ULTIMO = c_ANCHO_CNT'(ANCHO_PRODUCTO - 1);
    localparam logic [6:0] c_SEG_MENOS  = 7'b1111110;
    localparam logic [6:0] c_SEG_BLANCO = 7'b1111111;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        CONVERTIR = 2'd1,
        CARGAR    = 2'd2
    } estado_t;

    estado_t                   r_estado;
    estado_t                   w_estado_sig;
    logic                      w_captura;
    logic [c_ANCHO_CNT-1:0]    r_cuenta;
    logic [c_ANCHO_BCD-1:0]    r_bcd;
    logic [c_ANCHO_BCD-1:0]    w_bcd_aj;
    logic [ANCHO_PRODUCTO-1:0] r_magnitud;
    logic [ANCHO_PRODUCTO-1:0] w_magnitud;
    logic                      r_signo;
    logic [c_ANCHO_BCD-1:0]    r_buf_bcd;
    logic                      r_buf_signo;
    logic                      r_listo;
    logic [N_DIGITOS-1:0]      w_visible;
    logic [3:0]                w_nibble;
    logic [6:0]                w_seg;
    logic [7:0]                w_an;
    logic [7:0]                r_anodos;
    logic [6:0]                r_segmentos;

    function automatic logic [6:0] f_segmentos(input logic [3:0] d);
        case (d)
            4'd0:    f_segmentos = 7'b0000001;
            4'd1:    f_segmentos = 7'b1001111;
            4'd2:    f_segmentos = 7'b0010010;
            4'd3:    f_segmentos = 7'b0000110;
            4'd4:    f_segmentos = 7'b1001100;
            4'd5:    f_segmentos = 7'b0100100;
            4'd6:    f_segmentos = 7'b0100000;
            4'd7:    f_segmentos = 7'b0001111;
            4'd8:    f_segmentos = 7'b0000000;
            4'd9:    f_segmentos = 7'b0000100;
            default: f_segmentos = c_SEG_BLANCO;
        endcase
    endfunction

    // Unsigned negate: the most negative input maps to 2^(N-1), which fits
    // exactly as an unsigned N-bit magnitude.
    assign w_magnitud = producto[ANCHO_PRODUCTO-1] ? (~producto + 1'b1) : producto;

    always_comb begin
        w_estado_sig = r_estado;
        w_captura    = 1'b0;
        case (r_estado)
            REPOSO: begin
                // The post-load cycle still counts as busy, so no capture then.
                if (producto_valido && !r_listo) begin
                    w_captura    = 1'b1;
                    w_estado_sig = CONVERTIR;
                end
            end
            CONVERTIR: if (r_cuenta == c_ULTIMO) w_estado_sig = CARGAR;
            CARGAR:    w_estado_sig = REPOSO;
            default:   w_estado_sig = REPOSO;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITOS; gi++) begin : g_ajuste
            assign w_bcd_aj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                         (r_bcd[4*gi +: 4] + 4'd3) : r_bcd[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge reloj) begin
        if (reset) begin
            r_estado    <= REPOSO;
            r_cuenta    <= '0;
            r_bcd       <= '0;
            r_magnitud  <= '0;
            r_signo     <= 1'b0;
            r_buf_bcd   <= '0;
            r_buf_signo <= 1'b0;
            r_listo     <= 1'b0;
        end else begin
            r_estado <= w_estado_sig;
            r_listo  <= 1'b0;
            case (r_estado)
                REPOSO: begin
                    if (w_captura) begin
                        r_signo    <= producto[ANCHO_PRODUCTO-1];
                        r_magnitud <= w_magnitud;
                        r_bcd      <= '0;
                        r_cuenta   <= '0;
                    end
                end
                CONVERTIR: begin
                    {r_bcd, r_magnitud} <= {w_bcd_aj[c_ANCHO_BCD-2:0], r_magnitud, 1'b0};
                    r_cuenta            <= r_cuenta + 1'b1;
                end
                CARGAR: begin
                    r_buf_bcd   <= r_bcd;
                    r_buf_signo <= r_signo;
                    r_listo     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Leading-zero blanking: digit k is lit if it or any higher digit is nonzero.
    generate
        for (gi = 0; gi < N_DIGITOS; gi++) begin : g_visible
            if (gi == 0) begin : g_cero
                assign w_visible[gi] = 1'b1;
            end else begin : g_resto
                assign w_visible[gi] = |r_buf_bcd[c_ANCHO_BCD-1:4*gi];
            end
        end
    endgenerate

    always_comb begin
        w_seg    = c_SEG_BLANCO;
        w_an     = 8'hFF;
        w_nibble = 4'd0;
        if (contador_actualizar < 3'(N_DIGITOS)) begin
            if (w_visible[contador_actualizar]) begin
                w_nibble = r_buf_bcd[{contador_actualizar, 2'b00} +: 4];
                w_seg    = f_segmentos(w_nibble);
                w_an     = ~(8'd1 << contador_actualizar);
            end
        end else if (contador_actualizar == 3'(N_DIGITOS) && r_buf_signo) begin
            w_seg = c_SEG_MENOS;
            w_an  = ~(8'd1 << contador_actualizar);
        end
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            r_anodos    <= 8'hFF;
            r_segmentos <= c_SEG_BLANCO;
        end else begin
            r_anodos    <= w_an;
            r_segmentos <= w_seg;
        end
    end

    assign ocupado   = (r_estado != REPOSO) || r_listo;
    assign listo     = r_listo;
    assign anodos    = r_anodos;
    assign segmentos = r_segmentos;

endmodule
`default_nettype wire

// File: tb/tb_visualizador_producto.sv
`default_nettype none
// ============================================================================
// Module  : tb_visualizador_producto
// Brief   : Self-checking bench for visualizador_producto (vector table,
//           expected-result queue, multi-cycle corner sequences).
// Revision: 1.0  initial release
// ============================================================================
module tb_visualizador_producto;

    localparam logic [6:0] D0 = 7'b0000001, D1 = 7'b1001111, D2 = 7'b0010010;
    localparam logic [6:0] D3 = 7'b0000110, D4 = 7'b1001100, D5 = 7'b0100100;
    localparam logic [6:0] D6 = 7'b0100000, D7 = 7'b0001111, D8 = 7'b0000000;
    localparam logic [6:0] MN = 7'b1111110, BL = 7'b1111111;

    typedef struct packed {
        logic [15:0]     p;
        logic [7:0][6:0] seg;   // expected segments per display position
    } vec_t;

    logic        reloj = 1'b0;
    logic        reset = 1'b1;
    logic        producto_valido = 1'b0;
    logic [15:0] producto = '0;
    logic [2:0]  contador_actualizar = '0;
    logic        ocupado, listo;
    logic [7:0]  anodos;
    logic [6:0]  segmentos;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t v [7];
    vec_t sb_q [$];

    always #5 reloj = ~reloj;

    visualizador_producto #(.ANCHO_PRODUCTO(16), .N_DIGITOS(5)) dut (
        .reloj               (reloj),
        .reset               (reset),
        .producto_valido     (producto_valido),
        .producto            (producto),
        .contador_actualizar (contador_actualizar),
        .ocupado             (ocupado),
        .listo               (listo),
        .anodos              (anodos),
        .segmentos           (segmentos)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic strobe(input logic [15:0] p);
        @(negedge reloj);
        producto        = p;
        producto_valido = 1'b1;
        @(posedge reloj);
        #1 producto_valido = 1'b0;
    endtask

    // Called just after the strobe edge E0; returns edges until listo is seen.
    task automatic wait_listo(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge reloj);
            lat++;
            @(negedge reloj);
            if (listo) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_listo(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge reloj);
            if (listo) n++;
        end
    endtask

    task automatic check_display(input vec_t e, input string tag);
        logic [7:0] one;
        logic [7:0] exp_an;
        one = 8'd1;
        for (int k = 0; k < 8; k++) begin
            @(negedge reloj);
            contador_actualizar = 3'(k);
            @(negedge reloj);
            exp_an = (e.seg[k] == BL) ? 8'hFF : ~(one << k);
            check($sformatf("%s_anodos_pos%0d", tag, k), 32'(anodos), 32'(exp_an));
            check($sformatf("%s_seg_pos%0d", tag, k), 32'(segmentos), 32'(e.seg[k]));
        end
        @(negedge reloj);
        contador_actualizar = 3'd0;
    endtask

    initial begin
        int   lat;
        bit   ok;
        int   n;
        vec_t e;
        vec_t v42;

        v[0].p = 16'h0005; v[0].seg = {BL, BL, BL, BL, BL, BL, BL, D5};
        v[1].p = 16'hFB2E; v[1].seg = {BL, BL, MN, BL, D1, D2, D3, D4};
        v[2].p = 16'h8000; v[2].seg = {BL, BL, MN, D3, D2, D7, D6, D8};
        v[3].p = 16'h7FFF; v[3].seg = {BL, BL, BL, D3, D2, D7, D6, D7};
        v[4].p = 16'd1000; v[4].seg = {BL, BL, BL, BL, D1, D0, D0, D0};
        v[5].p = 16'h0000; v[5].seg = {BL, BL, BL, BL, BL, BL, BL, D0};
        v[6].p = 16'd42;   v[6].seg = {BL, BL, BL, BL, BL, BL, D4, D2};
        v42 = v[6];

        // Reset values, then the first display cycles.
        repeat (3) @(posedge reloj);
        @(negedge reloj);
        check("rst_anodos", 32'(anodos), 32'h0FF);
        check("rst_segmentos", 32'(segmentos), 32'h07F);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        check("rst_listo", 32'(listo), 32'd0);
        reset = 1'b0;
        @(negedge reloj);
        check("post_rst_anodos_pos0", 32'(anodos), 32'h0FE);
        check("post_rst_seg_pos0", 32'(segmentos), 32'(D0));
        contador_actualizar = 3'd1;
        @(negedge reloj);
        check("post_rst_anodos_pos1", 32'(anodos), 32'h0FF);
        check("post_rst_seg_pos1", 32'(segmentos), 32'(BL));
        contador_actualizar = 3'd0;

        // Vector table: expected result queued at strobe, popped on listo.
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back(v[i]);
            strobe(v[i].p);
            check("ocupado_tras_E0", 32'(ocupado), 32'd1);
            wait_listo(lat, ok);
            check("listo_visto", 32'(ok), 32'd1);
            check("latencia", 32'(lat), 32'd17);
            check("ocupado_en_listo", 32'(ocupado), 32'd1);
            e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            @(negedge reloj);
            check("listo_un_ciclo", 32'(listo), 32'd0);
            check("ocupado_cae", 32'(ocupado), 32'd0);
            check_display(e, $sformatf("vec%0d", i));
        end

        // Second strobe at E5 must be ignored.
        sb_q.push_back(v42);
        strobe(16'd42);
        repeat (4) @(posedge reloj);
        @(negedge reloj);
        producto        = 16'd999;
        producto_valido = 1'b1;
        @(posedge reloj);
        #1 producto_valido = 1'b0;
        count_listo(30, n);
        check("e5_listo_una_vez", 32'(n), 32'd1);
        check("e5_ocupado_final", 32'(ocupado), 32'd0);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        check_display(e, "e5");

        // Reset at E8 aborts the conversion and clears the display.
        strobe(16'd77);
        repeat (7) @(posedge reloj);
        @(negedge reloj);
        reset = 1'b1;
        @(negedge reloj);
        check("abort_ocupado", 32'(ocupado), 32'd0);
        check("abort_listo", 32'(listo), 32'd0);
        reset = 1'b0;
        count_listo(25, n);
        check("abort_sin_listo", 32'(n), 32'd0);
        check_display(v[5], "abort");

        // Strobe coincident with reset is dropped.
        @(negedge reloj);
        reset           = 1'b1;
        producto        = 16'd5;
        producto_valido = 1'b1;
        @(posedge reloj);
        #1 producto_valido = 1'b0;
        @(negedge reloj);
        reset = 1'b0;
        check("rst_strobe_ocupado", 32'(ocupado), 32'd0);
        count_listo(25, n);
        check("rst_strobe_sin_listo", 32'(n), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
